// File: rtl/sprite_anim_ram.sv
// sprite_anim_ram: multi-frame sprite bitmap RAM with a 2-stage mirrored read port,
// an independent write port and a frame_tick-driven animation sequencer.
// Optional macro SPRITE_ANIM_RAM_BYPASS_EN: write-first forwarding into the read port.
module sprite_anim_ram #(
  parameter int    X_BITS     = 5,
  parameter int    Y_BITS     = 5,
  parameter int    DATA_WIDTH = 2,
  parameter int    NUM_FRAMES = 4,
  parameter int    TICK_DIV   = 8,
  parameter string INIT_FILE  = "",
  localparam int   FB         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [X_BITS-1:0]     rd_x,
  input  logic [Y_BITS-1:0]     rd_y,
  input  logic                  mirror_x,
  input  logic                  anim_en,
  input  logic [FB-1:0]         frame_sel,
  input  logic                  frame_tick,
  input  logic                  we,
  input  logic [FB-1:0]         wr_frame,
  input  logic [X_BITS-1:0]     wr_x,
  input  logic [Y_BITS-1:0]     wr_y,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic [FB-1:0]         cur_frame,
  output logic                  frame_wrap
);

  localparam int PIX_BITS = X_BITS + Y_BITS;
  localparam int AW       = FB + PIX_BITS;
  localparam int DEPTH    = NUM_FRAMES * (2 ** PIX_BITS);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [FB-1:0]     LAST_FRAME = FB'(NUM_FRAMES - 1);
  localparam logic [TW-1:0]     LAST_TICK  = TW'(TICK_DIV - 1);
  localparam logic [X_BITS-1:0] X_MAX      = '1;

  function automatic logic [FB-1:0] sat_frame(input logic [FB-1:0] f);
    return (32'(f) >= 32'(NUM_FRAMES)) ? LAST_FRAME : f;
  endfunction

  function automatic logic frame_in_range(input logic [FB-1:0] f);
    return 32'(f) < 32'(NUM_FRAMES);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Frame indices are packed above {y, x}, so the linear address is a plain concatenation.
  logic          wr_hit;
  logic [AW-1:0] wr_addr;
  assign wr_hit  = we && frame_in_range(wr_frame);
  assign wr_addr = {wr_frame, wr_y, wr_x};

  always_ff @(posedge clk) begin
    if (wr_hit) mem[wr_addr] <= din;
  end

  logic [TW-1:0]         tick_q, tick_d;
  logic [FB-1:0]         cur_frame_q, cur_frame_d;
  logic                  wrap_q, wrap_d;
  logic [X_BITS-1:0]     x_p1_q, x_p1_d;
  logic [Y_BITS-1:0]     y_p1_q, y_p1_d;
  logic [FB-1:0]         frame_p1_q, frame_p1_d;
  logic                  vld_p1_q;
  logic [AW-1:0]         rd_addr_p1;
  logic [DATA_WIDTH-1:0] dout_p2_q;
  logic                  vld_p2_q;

  always_comb begin
    tick_d      = tick_q;
    cur_frame_d = cur_frame_q;
    wrap_d      = 1'b0;
    if (anim_en && frame_tick) begin
      if (tick_q == LAST_TICK) begin
        tick_d = '0;
        if (cur_frame_q == LAST_FRAME) begin
          cur_frame_d = '0;
          wrap_d      = 1'b1;
        end else begin
          cur_frame_d = cur_frame_q + 1'b1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // Stage 1: resolve mirrored column and effective frame (pre-edge cur_frame).
  always_comb begin
    x_p1_d     = x_p1_q;
    y_p1_d     = y_p1_q;
    frame_p1_d = frame_p1_q;
    if (rd_en) begin
      x_p1_d     = mirror_x ? (X_MAX - rd_x) : rd_x;
      y_p1_d     = rd_y;
      frame_p1_d = anim_en ? cur_frame_q : sat_frame(frame_sel);
    end
  end

  assign rd_addr_p1 = {frame_p1_q, y_p1_q, x_p1_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q      <= '0;
      cur_frame_q <= '0;
      wrap_q      <= 1'b0;
      x_p1_q      <= '0;
      y_p1_q      <= '0;
      frame_p1_q  <= '0;
      vld_p1_q    <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      cur_frame_q <= cur_frame_d;
      wrap_q      <= wrap_d;
      x_p1_q      <= x_p1_d;
      y_p1_q      <= y_p1_d;
      frame_p1_q  <= frame_p1_d;
      vld_p1_q    <= rd_en;
    end
  end

  // Stage 2: synchronous memory read; dout holds when no read is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
`ifdef SPRITE_ANIM_RAM_BYPASS_EN
      if (vld_p1_q) begin
        if (wr_hit && (wr_addr == rd_addr_p1)) dout_p2_q <= din;
        else                                   dout_p2_q <= mem[rd_addr_p1];
      end
`else
      if (vld_p1_q) dout_p2_q <= mem[rd_addr_p1];
`endif
    end
  end

  assign dout       = dout_p2_q;
  assign rd_valid   = vld_p2_q;
  assign cur_frame  = cur_frame_q;
  assign frame_wrap = wrap_q;

endmodule

// File: tb/tb_sprite_anim_ram.sv
// Scoreboard bench for sprite_anim_ram: a default 32x32x4 instance plus a small
// 3-frame instance exercising out-of-range frame clamping and non-power-of-two wrap.
module tb_sprite_anim_ram;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       rd_en, mirror_x, anim_en, frame_tick, we;
  logic [4:0] rd_x, rd_y, wr_x, wr_y;
  logic [1:0] frame_sel, wr_frame, din, dout, cur_frame;
  logic       rd_valid, frame_wrap;

  logic       b_rd_en, b_mirror_x, b_anim_en, b_frame_tick, b_we;
  logic [1:0] b_rd_x, b_rd_y, b_wr_x, b_wr_y, b_frame_sel, b_wr_frame, b_din, b_dout, b_cur_frame;
  logic       b_rd_valid, b_frame_wrap;

`ifdef SPRITE_ANIM_RAM_BYPASS_EN
  localparam logic [1:0] RDW_EXP = 2'd3;
`else
  localparam logic [1:0] RDW_EXP = 2'd1;
`endif

  sprite_anim_ram u_dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .mirror_x(mirror_x),
    .anim_en(anim_en), .frame_sel(frame_sel), .frame_tick(frame_tick), .we(we),
    .wr_frame(wr_frame), .wr_x(wr_x), .wr_y(wr_y), .din(din), .dout(dout),
    .rd_valid(rd_valid), .cur_frame(cur_frame), .frame_wrap(frame_wrap)
  );

  sprite_anim_ram #(.X_BITS(2), .Y_BITS(2), .DATA_WIDTH(2), .NUM_FRAMES(3), .TICK_DIV(2)) u_nf3 (
    .clk(clk), .reset(reset), .rd_en(b_rd_en), .rd_x(b_rd_x), .rd_y(b_rd_y), .mirror_x(b_mirror_x),
    .anim_en(b_anim_en), .frame_sel(b_frame_sel), .frame_tick(b_frame_tick), .we(b_we),
    .wr_frame(b_wr_frame), .wr_x(b_wr_x), .wr_y(b_wr_y), .din(b_din), .dout(b_dout),
    .rd_valid(b_rd_valid), .cur_frame(b_cur_frame), .frame_wrap(b_frame_wrap)
  );

  typedef struct { logic [1:0] data; string tag; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Monitor: pop expected read data whenever a DUT presents rd_valid.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rd_valid main: got dout %0d, expected no valid", dout);
      end else begin
        e0 = q0.pop_front();
        check(e0.tag, 32'(dout), 32'(e0.data));
      end
    end
    if (b_rd_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rd_valid nf3: got dout %0d, expected no valid", b_dout);
      end else begin
        e1 = q1.pop_front();
        check(e1.tag, 32'(b_dout), 32'(e1.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rd_en = 1'b0; we = 1'b0; frame_tick = 1'b0;
      b_rd_en = 1'b0; b_we = 1'b0; b_frame_tick = 1'b0;
    end
  endtask

  task automatic issue_rd(input int fs, input int x, input int y, input int m,
                          input logic [1:0] want, input string tag);
    @(negedge clk);
    rd_en = 1'b1; we = 1'b0; frame_tick = 1'b0;
    frame_sel = 2'(fs); rd_x = 5'(x); rd_y = 5'(y); mirror_x = 1'(m);
    q0.push_back('{want, tag});
  endtask

  task automatic issue_rd3(input int fs, input int x, input int y, input int m,
                           input logic [1:0] want, input string tag);
    @(negedge clk);
    b_rd_en = 1'b1; b_we = 1'b0; b_frame_tick = 1'b0;
    b_frame_sel = 2'(fs); b_rd_x = 2'(x); b_rd_y = 2'(y); b_mirror_x = 1'(m);
    q1.push_back('{want, tag});
  endtask

  task automatic wr3(input int f, input int x, input int y, input int d);
    @(negedge clk);
    b_we = 1'b1; b_wr_frame = 2'(f); b_wr_x = 2'(x); b_wr_y = 2'(y); b_din = 2'(d);
    idle(1);
  endtask

  task automatic tick(input bit main_dut);
    @(negedge clk);
    rd_en = 1'b0; b_rd_en = 1'b0;
    if (main_dut) frame_tick = 1'b1;
    else          b_frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; b_frame_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_en = 0; mirror_x = 0; anim_en = 0; frame_tick = 0; we = 0;
    rd_x = 0; rd_y = 0; wr_x = 0; wr_y = 0; frame_sel = 0; wr_frame = 0; din = 0;
    b_rd_en = 0; b_mirror_x = 0; b_anim_en = 0; b_frame_tick = 0; b_we = 0;
    b_rd_x = 0; b_rd_y = 0; b_wr_x = 0; b_wr_y = 0; b_frame_sel = 0; b_wr_frame = 0; b_din = 0;

    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_cur_frame", 32'(cur_frame), 0);
    check("rst_frame_wrap", 32'(frame_wrap), 0);
    reset = 1'b0;

    // Image: frame f pixel (x,y) = (f+x+y)%4
    for (int f = 0; f < 4; f++)
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++) begin
          @(negedge clk);
          we = 1'b1; wr_frame = 2'(f); wr_y = 5'(y); wr_x = 5'(x); din = 2'((f + x + y) % 4);
        end
    idle(2);

    issue_rd(2, 3, 1, 0, 2'd2, "f2_x3_y1");
    @(negedge clk);
    rd_en = 1'b0;
    check("latency_not_1", 32'(rd_valid), 0);
    idle(3);

    issue_rd(2, 1, 0, 0, 2'd3, "b2b_f2_x1_y0");
    issue_rd(2, 31, 31, 0, 2'd0, "b2b_f2_x31_y31");
    issue_rd(2, 6, 0, 0, 2'd0, "b2b_f2_x6_y0");
    issue_rd(2, 4, 9, 0, 2'd3, "b2b_f2_x4_y9");
    idle(4);
    check("hold_dout", 32'(dout), 3);
    check("hold_no_valid", 32'(rd_valid), 0);

    issue_rd(2, 0, 0, 1, 2'd1, "mirror_x0");
    issue_rd(2, 31, 0, 1, 2'd2, "mirror_x31");
    issue_rd(2, 1, 3, 1, 2'd3, "mirror_x1_y3");
    issue_rd(3, 3, 1, 0, 2'd3, "fs3_x3_y1");
    issue_rd(0, 3, 1, 0, 2'd0, "fs0_x3_y1");
    issue_rd(1, 3, 1, 0, 2'd1, "fs1_x3_y1");
    idle(3);

    issue_rd(1, 2, 2, 0, RDW_EXP, "rdw_same_cycle");
    @(negedge clk);
    rd_en = 1'b0; we = 1'b1; wr_frame = 2'd1; wr_x = 5'd2; wr_y = 5'd2; din = 2'd3;
    idle(1);
    issue_rd(1, 2, 2, 0, 2'd3, "rdw_next_read");
    idle(3);

    anim_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick(1'b1);
      check($sformatf("seq_cur_t%0d", k), 32'(cur_frame), (k / 8) % 4);
      check($sformatf("seq_wrap_t%0d", k), 32'(frame_wrap), (k == 32) ? 1 : 0);
    end
    @(negedge clk);
    check("wrap_one_cycle", 32'(frame_wrap), 0);

    repeat (8) tick(1'b1);
    check("seq_cur_f1", 32'(cur_frame), 1);
    issue_rd(3, 2, 3, 0, 2'd2, "anim_f1");
    idle(3);

    repeat (3) tick(1'b1);
    anim_en = 1'b0;
    repeat (10) tick(1'b1);
    check("frozen_cur", 32'(cur_frame), 1);
    anim_en = 1'b1;
    repeat (4) tick(1'b1);
    check("resume_cnt7_cur", 32'(cur_frame), 1);
    issue_rd(3, 0, 1, 0, 2'd2, "same_edge_pre_frame");
    frame_tick = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; frame_tick = 1'b0;
    check("advance_at_8", 32'(cur_frame), 2);
    issue_rd(3, 0, 1, 0, 2'd3, "anim_f2");
    idle(3);
    anim_en = 1'b0;

    // Reset lands between rd_en and the stage-2 read.
    @(negedge clk);
    rd_en = 1'b1; rd_x = 5'd0; rd_y = 5'd0; mirror_x = 1'b0; frame_sel = 2'd0;
    @(negedge clk);
    rd_en = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_dout", 32'(dout), 0);
    check("midrst_rd_valid", 32'(rd_valid), 0);
    check("midrst_cur_frame", 32'(cur_frame), 0);
    check("midrst_frame_wrap", 32'(frame_wrap), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_no_valid_%0d", i), 32'(rd_valid), 0);
    end
    check("post_rst_cur_frame", 32'(cur_frame), 0);

    wr3(0, 1, 1, 1);
    wr3(1, 1, 1, 3);
    wr3(2, 1, 1, 2);
    wr3(3, 1, 1, 0);
    issue_rd3(2, 1, 1, 0, 2'd2, "nf3_f2_untouched");
    issue_rd3(3, 1, 1, 0, 2'd2, "nf3_fs3_clamped");
    issue_rd3(0, 1, 1, 0, 2'd1, "nf3_f0");
    issue_rd3(1, 1, 1, 0, 2'd3, "nf3_f1");
    issue_rd3(0, 2, 1, 1, 2'd1, "nf3_mirror_x2");
    idle(3);

    b_anim_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0);
      check($sformatf("nf3_cur_t%0d", k), 32'(b_cur_frame), (k / 2) % 3);
      check($sformatf("nf3_wrap_t%0d", k), 32'(b_frame_wrap), (k == 6) ? 1 : 0);
    end
    b_anim_en = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    while (q0.size() != 0) begin
      e0 = q0.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: got no rd_valid, expected dout %0d", e0.tag, e0.data);
    end
    while (q1.size() != 0) begin
      e1 = q1.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s: got no rd_valid, expected dout %0d", e1.tag, e1.data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
